// File: rtl/pwm_pkg.sv
// Shared constants for the multichannel PWM peripheral:
// register map, CTRL bit positions, mode and direction encodings.
package pwm_pkg;

    localparam int ADDR_CTRL      = 'h00;
    localparam int ADDR_PRESCALE  = 'h01;
    localparam int ADDR_TOP       = 'h02;
    localparam int ADDR_DUTY_BASE = 'h10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, edge/centre counter, update event
// and the registered period_start pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] prescale,
    input  logic [CNT_W-1:0] top,
    output logic [CNT_W-1:0] cnt,
    output logic             update,
    output logic             period_start
);

    logic [CNT_W-1:0] presc;
    logic             dir;
    logic             tick;

    assign tick = en && (presc == prescale);

    // In centre mode the event is the tick that would bring the
    // count back down to 0; TOP=1 reaches that point while counting up.
    always_comb begin
        update = 1'b0;
        if (tick) begin
            unique case (mode)
                MODE_EDGE: update = (cnt == top);
                MODE_CENTRE: begin
                    if (top == '0)
                        update = 1'b1;
                    else if (dir == DIR_DOWN)
                        update = (cnt <= CNT_W'(1));
                    else
                        update = (top == CNT_W'(1)) && (cnt == top);
                end
                default: update = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
        end else begin
            period_start <= update;
            if (!en) begin
                presc <= '0;
                cnt   <= '0;
                dir   <= DIR_UP;
            end else begin
                presc <= tick ? '0 : presc + CNT_W'(1);
                if (update) begin
                    cnt <= '0;
                    dir <= DIR_UP;
                end else if (tick) begin
                    if (mode == MODE_EDGE) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (dir == DIR_UP) begin
                        if (cnt == top) begin
                            dir <= DIR_DOWN;
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: pending/active register file with
// period-boundary shadowing and per-channel comparators.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    output logic [CNT_W-1:0]  cfg_rdata,
    input  logic [NUM_CH-1:0] ch_out_en,
    input  logic [NUM_CH-1:0] ch_pwm_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    logic             en;
    logic             pend_mode;
    logic             act_mode;
    logic [CNT_W-1:0] pend_presc;
    logic [CNT_W-1:0] act_presc;
    logic [CNT_W-1:0] pend_top;
    logic [CNT_W-1:0] act_top;
    logic [CNT_W-1:0] pend_duty [NUM_CH];
    logic [CNT_W-1:0] act_duty  [NUM_CH];

    logic             sel_ctrl;
    logic             sel_presc;
    logic             sel_top;
    logic [NUM_CH-1:0] sel_duty;

    logic [CNT_W-1:0] cnt;
    logic             update;

    assign sel_ctrl  = (cfg_addr == ADDR_W'(ADDR_CTRL));
    assign sel_presc = (cfg_addr == ADDR_W'(ADDR_PRESCALE));
    assign sel_top   = (cfg_addr == ADDR_W'(ADDR_TOP));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel_duty[i] = (cfg_addr == ADDR_W'(ADDR_DUTY_BASE + i));
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (1'b1)
            sel_ctrl:  cfg_rdata = CNT_W'({pend_mode, en});
            sel_presc: cfg_rdata = pend_presc;
            sel_top:   cfg_rdata = pend_top;
            default:   cfg_rdata = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_duty[i]) cfg_rdata = pend_duty[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            pend_mode  <= MODE_EDGE;
            pend_presc <= '0;
            pend_top   <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_duty[i] <= '0;
            end
        end else if (cfg_we) begin
            if (sel_ctrl) begin
                en        <= cfg_wdata[CTRL_EN_BIT];
                pend_mode <= cfg_wdata[CTRL_MODE_BIT];
            end
            if (sel_presc) pend_presc <= cfg_wdata;
            if (sel_top)   pend_top   <= cfg_wdata;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_duty[i]) pend_duty[i] <= cfg_wdata;
            end
        end
    end

    // Actives follow pending freely while disabled, otherwise only
    // at the update event (a coinciding write lands one period later).
    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode  <= MODE_EDGE;
            act_presc <= '0;
            act_top   <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                act_duty[i] <= '0;
            end
        end else if (!en || update) begin
            act_mode  <= pend_mode;
            act_presc <= pend_presc;
            act_top   <= pend_top;
            for (int i = 0; i < NUM_CH; i++) begin
                act_duty[i] <= pend_duty[i];
            end
        end
    end

    pwm_timebase #(
        .CNT_W(CNT_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (act_mode),
        .prescale    (act_presc),
        .top         (act_top),
        .cnt         (cnt),
        .update      (update),
        .period_start(period_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= ch_out_en[i] &
                    (~ch_pwm_en[i] | (en & (cnt < act_duty[i])));
            end
        end
    end

endmodule
